// File: rtl/ex_mem_forward_stage_pkg.sv
// ex_mem_forward_stage_pkg: ALU opcodes, forwarding select codes and ctrl bit positions
// shared by the EX stage, its ALU and the EX/MEM register.
package ex_mem_forward_stage_pkg;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    // ctrl word layout: {branch, memwrite, memread, memtoreg, regwrite}
    localparam int CTRL_W        = 5;
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_MEMREAD  = 2;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_BRANCH   = 4;
endpackage

// File: rtl/ex_mem_forward_stage_if.sv
// ex_mem_forward_stage_if: ID/EX operands, write-back state and EX/MEM outputs of the EX stage.
// slave is the stage's view, master is the driver's view.
interface ex_mem_forward_stage_if #(
    parameter int XLEN = 64,
    parameter int RA_W = 5
);
    logic [3:0]      alu_ctrl;
    logic            alusrc;
    logic [RA_W-1:0] id_ex_rs1;
    logic [RA_W-1:0] id_ex_rs2;
    logic [RA_W-1:0] id_ex_rd;
    logic [XLEN-1:0] id_ex_rd1;
    logic [XLEN-1:0] id_ex_rd2;
    logic [XLEN-1:0] id_ex_imm;
    logic [XLEN-1:0] next_pc_in;
    logic [4:0]      ctrl_in;
    logic [RA_W-1:0] mem_wb_rd;
    logic            mem_wb_regwrite;
    logic [XLEN-1:0] mem_wb_data;
    logic            flush;
    logic [1:0]      forward_a;
    logic [1:0]      forward_b;
    logic [XLEN-1:0] alu_result;
    logic            zero;
    logic [XLEN-1:0] ex_mem_pc;
    logic [XLEN-1:0] ex_mem_alu_result;
    logic [XLEN-1:0] ex_mem_store_data;
    logic            ex_mem_zero;
    logic [RA_W-1:0] ex_mem_rd;
    logic [4:0]      ex_mem_ctrl;

    modport slave (
        input  alu_ctrl, alusrc, id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_rd1, id_ex_rd2, id_ex_imm,
               next_pc_in, ctrl_in, mem_wb_rd, mem_wb_regwrite, mem_wb_data, flush,
        output forward_a, forward_b, alu_result, zero, ex_mem_pc, ex_mem_alu_result,
               ex_mem_store_data, ex_mem_zero, ex_mem_rd, ex_mem_ctrl
    );

    modport master (
        output alu_ctrl, alusrc, id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_rd1, id_ex_rd2, id_ex_imm,
               next_pc_in, ctrl_in, mem_wb_rd, mem_wb_regwrite, mem_wb_data, flush,
        input  forward_a, forward_b, alu_result, zero, ex_mem_pc, ex_mem_alu_result,
               ex_mem_store_data, ex_mem_zero, ex_mem_rd, ex_mem_ctrl
    );
endinterface

// File: rtl/ex_mem_forward_stage_alu.sv
// ex_alu: combinational EX-stage ALU; AND/OR/ADD/SUB always, XOR/SLL/SRL/SLT with ALU_EXT_OPS_EN.
// Codes not enabled in the build produce 0.
module ex_alu
    import ex_mem_forward_stage_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            zero
);
    always_comb begin
        result = '0;
        case (alu_ctrl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
`ifdef ALU_EXT_OPS_EN
            ALU_XOR: result = a ^ b;
            ALU_SLL: result = a << b[5:0];
            ALU_SRL: result = a >> b[5:0];
            ALU_SLT: result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
`endif
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);
endmodule

// File: rtl/ex_mem_forward_stage.sv
// ex_mem_forward_stage: EX stage with operand forwarding, ALU and the EX/MEM pipeline register.
// Build option ALU_EXT_OPS_EN enables the extended ALU opcodes in ex_alu.
module ex_mem_forward_stage
    import ex_mem_forward_stage_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int RA_W = 5
) (
    input logic clock,
    input logic reset,
    ex_mem_forward_stage_if.slave bus
);
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [XLEN-1:0]   src_a;
    logic [XLEN-1:0]   src_b;
    logic [XLEN-1:0]   alu_y;
    logic              alu_z;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   res_q;
    logic [XLEN-1:0]   store_q;
    logic              zero_q;
    logic [RA_W-1:0]   rd_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic              mem_hit_a;
    logic              mem_hit_b;
    logic              wb_hit_a;
    logic              wb_hit_b;

    // Hazard detection looks at the registered EX/MEM fields, i.e. the instruction one ahead.
    assign mem_hit_a = ctrl_q[CTRL_REGWRITE] && rd_q != '0 && rd_q == bus.id_ex_rs1;
    assign mem_hit_b = ctrl_q[CTRL_REGWRITE] && rd_q != '0 && rd_q == bus.id_ex_rs2;
    assign wb_hit_a  = bus.mem_wb_regwrite && bus.mem_wb_rd != '0 && bus.mem_wb_rd == bus.id_ex_rs1;
    assign wb_hit_b  = bus.mem_wb_regwrite && bus.mem_wb_rd != '0 && bus.mem_wb_rd == bus.id_ex_rs2;

    assign fwd_a = mem_hit_a ? FWD_MEM : wb_hit_a ? FWD_WB : FWD_NONE;
    assign fwd_b = mem_hit_b ? FWD_MEM : wb_hit_b ? FWD_WB : FWD_NONE;

    // Select code 11 never arises from the hazard logic and falls back to the register file.
    assign src_a = fwd_a == FWD_MEM ? res_q : fwd_a == FWD_WB ? bus.mem_wb_data : bus.id_ex_rd1;
    assign src_b = fwd_b == FWD_MEM ? res_q : fwd_b == FWD_WB ? bus.mem_wb_data : bus.id_ex_rd2;

    ex_alu #(.XLEN(XLEN)) u_alu (
        .alu_ctrl (bus.alu_ctrl),
        .a        (src_a),
        .b        (bus.alusrc ? bus.id_ex_imm : src_b),
        .result   (alu_y),
        .zero     (alu_z)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q    <= '0;
            res_q   <= '0;
            store_q <= '0;
            zero_q  <= 1'b0;
            rd_q    <= '0;
            ctrl_q  <= '0;
        end else begin
            pc_q    <= bus.next_pc_in;
            res_q   <= alu_y;
            store_q <= src_b;
            zero_q  <= alu_z;
            rd_q    <= bus.flush ? '0 : bus.id_ex_rd;
            ctrl_q  <= bus.flush ? '0 : bus.ctrl_in;
        end
    end

    assign bus.forward_a         = fwd_a;
    assign bus.forward_b         = fwd_b;
    assign bus.alu_result        = alu_y;
    assign bus.zero              = alu_z;
    assign bus.ex_mem_pc         = pc_q;
    assign bus.ex_mem_alu_result = res_q;
    assign bus.ex_mem_store_data = store_q;
    assign bus.ex_mem_zero       = zero_q;
    assign bus.ex_mem_rd         = rd_q;
    assign bus.ex_mem_ctrl       = ctrl_q;
endmodule

// File: tb/tb_ex_mem_forward_stage.sv
// tb_ex_mem_forward_stage: directed and random vectors scored against a register-newest-writer model.
module tb_ex_mem_forward_stage;
    localparam int XLEN = 64;
    localparam int RA_W = 5;

    typedef struct {
        logic            rst;
        logic            flush;
        logic            alusrc;
        logic [3:0]      op;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] npc;
        logic [4:0]      ctrl;
        logic [RA_W-1:0] wb_rd;
        logic            wb_we;
        logic [XLEN-1:0] wb_data;
    } stim_t;

    typedef struct {
        logic            chk_comb;
        logic [1:0]      fa;
        logic [1:0]      fb;
        logic [XLEN-1:0] alu;
        logic            zero;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] res;
        logic [XLEN-1:0] store;
        logic            zero_r;
        logic [RA_W-1:0] rd;
        logic [4:0]      ctrl;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   vectors = 0;
    int   checks = 0;
    int   miscompares = 0;
    exp_t q[$];

    logic            m_valid = 1'b0;
    logic [XLEN-1:0] m_pc, m_res, m_store;
    logic            m_zero;
    logic [RA_W-1:0] m_rd;
    logic [4:0]      m_ctrl;

    ex_mem_forward_stage_if #(.XLEN(XLEN), .RA_W(RA_W)) bus ();

    ex_mem_forward_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [XLEN-1:0] ref_alu(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        case (op)
            4'd0: return a & b;
            4'd1: return a | b;
            4'd2: return a + b;
            4'd6: return a - b;
`ifdef ALU_EXT_OPS_EN
            4'd3: return a ^ b;
            4'd4: return a << b[5:0];
            4'd5: return a >> b[5:0];
            4'd7: return ($signed(a) < $signed(b)) ? 1 : 0;
`endif
            default: return 0;
        endcase
    endfunction

    // Register value as EX sees it: the newest pending write to a nonzero register wins.
    task automatic resolve(input logic [RA_W-1:0] r, input logic [XLEN-1:0] rf, input stim_t s,
                           output logic [1:0] code, output logic [XLEN-1:0] v);
        code = 2'b00;
        v = rf;
        if (r != 0 && s.wb_we && s.wb_rd == r) begin
            code = 2'b01;
            v = s.wb_data;
        end
        if (r != 0 && m_ctrl[0] && m_rd == r) begin
            code = 2'b10;
            v = m_res;
        end
    endtask

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic stim_t quiet();
        stim_t s;
        s = '{rst: 0, flush: 0, alusrc: 0, op: 4'd2, rs1: 0, rs2: 0, rd: 0, rd1: 0, rd2: 0, imm: 0,
              npc: 0, ctrl: 0, wb_rd: 0, wb_we: 0, wb_data: 0};
        return s;
    endfunction

    function automatic logic [XLEN-1:0] rnd_word();
        return ($urandom_range(0, 2) == 0) ? XLEN'($urandom_range(0, 20)) : {$urandom, $urandom};
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        logic [3:0] ops[4] = '{4'd0, 4'd1, 4'd2, 4'd6};
        s = quiet();
        s.rst     = ($urandom_range(0, 49) == 0);
        s.flush   = ($urandom_range(0, 7) == 0);
        s.alusrc  = ($urandom_range(0, 3) == 0);
        s.op      = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : ops[$urandom_range(0, 3)];
        s.rs1     = RA_W'($urandom_range(0, 7));
        s.rs2     = RA_W'($urandom_range(0, 7));
        s.rd      = RA_W'($urandom_range(0, 7));
        s.rd1     = rnd_word();
        s.rd2     = ($urandom_range(0, 3) == 0) ? s.rd1 : rnd_word();
        s.imm     = rnd_word();
        s.npc     = {$urandom, $urandom};
        s.ctrl    = 5'($urandom);
        s.wb_rd   = RA_W'($urandom_range(0, 7));
        s.wb_we   = $urandom_range(0, 1) == 1;
        s.wb_data = rnd_word();
        return s;
    endfunction

    task automatic apply(input stim_t s);
        exp_t e;
        logic [XLEN-1:0] va, vb;
        @(negedge clock);
        reset               = s.rst;
        bus.flush           = s.flush;
        bus.alusrc          = s.alusrc;
        bus.alu_ctrl        = s.op;
        bus.id_ex_rs1       = s.rs1;
        bus.id_ex_rs2       = s.rs2;
        bus.id_ex_rd        = s.rd;
        bus.id_ex_rd1       = s.rd1;
        bus.id_ex_rd2       = s.rd2;
        bus.id_ex_imm       = s.imm;
        bus.next_pc_in      = s.npc;
        bus.ctrl_in         = s.ctrl;
        bus.mem_wb_rd       = s.wb_rd;
        bus.mem_wb_regwrite = s.wb_we;
        bus.mem_wb_data     = s.wb_data;
        e.chk_comb = m_valid;
        resolve(s.rs1, s.rd1, s, e.fa, va);
        resolve(s.rs2, s.rd2, s, e.fb, vb);
        e.alu  = ref_alu(s.op, va, s.alusrc ? s.imm : vb);
        e.zero = (e.alu == 0);
        if (s.rst) begin
            m_pc = 0; m_res = 0; m_store = 0; m_zero = 0; m_rd = 0; m_ctrl = 0;
            m_valid = 1'b1;
        end else begin
            m_pc = s.npc; m_res = e.alu; m_store = vb; m_zero = e.zero;
            m_rd = s.flush ? 0 : s.rd;
            m_ctrl = s.flush ? 0 : s.ctrl;
        end
        e.pc = m_pc; e.res = m_res; e.store = m_store; e.zero_r = m_zero; e.rd = m_rd; e.ctrl = m_ctrl;
        q.push_back(e);
        vectors++;
    endtask

    // Monitor: combinational outputs mid-cycle, registered outputs just after the edge.
    initial begin
        logic [1:0]      fa, fb;
        logic [XLEN-1:0] alu;
        logic            z;
        exp_t            e;
        forever begin
            @(negedge clock);
            #2;
            fa = bus.forward_a; fb = bus.forward_b; alu = bus.alu_result; z = bus.zero;
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.chk_comb) begin
                    chk("forward_a", XLEN'(fa), XLEN'(e.fa));
                    chk("forward_b", XLEN'(fb), XLEN'(e.fb));
                    chk("alu_result", alu, e.alu);
                    chk("zero", XLEN'(z), XLEN'(e.zero));
                end
                chk("ex_mem_pc", bus.ex_mem_pc, e.pc);
                chk("ex_mem_alu_result", bus.ex_mem_alu_result, e.res);
                chk("ex_mem_store_data", bus.ex_mem_store_data, e.store);
                chk("ex_mem_zero", XLEN'(bus.ex_mem_zero), XLEN'(e.zero_r));
                chk("ex_mem_rd", XLEN'(bus.ex_mem_rd), XLEN'(e.rd));
                chk("ex_mem_ctrl", XLEN'(bus.ex_mem_ctrl), XLEN'(e.ctrl));
            end
        end
    end

    initial begin
        stim_t s;
        reset = 1'b1;
        // Reset must win over a simultaneous flush.
        s = quiet(); s.rst = 1; s.flush = 1; s.ctrl = 5'b11111; s.rd = 9; s.npc = 64'h1234; apply(s);
        s = quiet(); s.rd1 = 5; s.rd2 = 3; s.rs1 = 1; s.rs2 = 2; s.rd = 5; s.ctrl = 5'b00001; apply(s);
        s = quiet(); s.rs1 = 5; s.rs2 = 2; s.rd1 = 1; s.rd2 = 2; apply(s);
        s = quiet(); s.rd1 = 5; s.rd2 = 3; s.rd = 5; s.ctrl = 5'b00001; apply(s);
        s = quiet(); s.rs1 = 5; s.wb_rd = 5; s.wb_we = 1; s.wb_data = 99; s.rd1 = 1; apply(s);
        s = quiet(); s.rs1 = 5; s.wb_rd = 5; s.wb_we = 1; s.wb_data = 99; s.rd1 = 1; apply(s);
        s = quiet(); s.op = 4'd6; s.rd1 = 7; s.rd2 = 7; apply(s);
        s = quiet(); s.rd1 = 4; s.rd = 0; s.ctrl = 5'b00001; apply(s);
        s = quiet(); s.rd1 = 6; s.rs1 = 0; s.rd2 = 1; apply(s);
        s = quiet(); s.flush = 1; s.ctrl = 5'b11111; s.rd = 9; s.rd1 = 3; s.npc = 64'h40; apply(s);
        s = quiet(); s.rs1 = 9; s.rd1 = 2; s.rd2 = 2; apply(s);
        s = quiet(); s.rd1 = 11; s.rd = 3; s.ctrl = 5'b10101; apply(s);
        s = quiet(); s.rst = 1; s.rd1 = 1; apply(s);
        s = quiet(); s.op = 4'd9; s.rd1 = 5; s.rd2 = 3; apply(s);
        s = quiet(); s.alusrc = 1; s.rs2 = 3; s.rd2 = 50; s.imm = 7; s.rd1 = 1; s.wb_rd = 3; s.wb_we = 1; s.wb_data = 77; apply(s);
        repeat (600) apply(rnd());
        repeat (3) @(negedge clock);
        chk("scoreboard_drain", XLEN'(q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ex_mem_forward_stage.md
EX_MEM_FORWARD_STAGE -- requirements
Module: ex_mem_forward_stage

Interface
REQ-001 Parameter XLEN, default 64: datapath width.
REQ-002 Parameter RA_W, default 5: register-address width.
REQ-003 clock  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 alu_ctrl  in  4  ALU operation code.
REQ-006 alusrc  in  1  1 = ALU operand B is id_ex_imm instead of forwarded rs2.
REQ-007 id_ex_rs1, id_ex_rs2  in  RA_W each  source register numbers.
REQ-008 id_ex_rd  in  RA_W  destination register number.
REQ-009 id_ex_rd1, id_ex_rd2, id_ex_imm  in  XLEN each  register-file operands and immediate.
REQ-010 next_pc_in  in  XLEN  branch target computed upstream.
REQ-011 ctrl_in  in  5  {branch, memwrite, memread, memtoreg, regwrite}.
REQ-012 mem_wb_rd  in  RA_W;  mem_wb_regwrite  in  1;  mem_wb_data  in  XLEN: write-back stage state.
REQ-013 flush  in  1  inserts a bubble into EX/MEM.
REQ-014 forward_a, forward_b  out  2 each  operand-select codes.
REQ-015 alu_result  out  XLEN;  zero  out  1: combinational ALU result and zero flag.
REQ-016 ex_mem_pc, ex_mem_alu_result, ex_mem_store_data  out  XLEN each  registered fields.
REQ-017 ex_mem_zero  out  1;  ex_mem_rd  out  RA_W;  ex_mem_ctrl  out  5  registered fields.

Function
REQ-018 forward_a SHALL be 2'b10 if ex_mem_ctrl.regwrite, ex_mem_rd!=0 and ex_mem_rd==id_ex_rs1; else 2'b01 if mem_wb_regwrite, mem_wb_rd!=0 and mem_wb_rd==id_ex_rs1; else 2'b00. forward_b SHALL use the same rule with id_ex_rs2. The EX/MEM match has priority.
REQ-019 Forwarded operand SHALL be 00 -> id_ex_rd1/rd2, 01 -> mem_wb_data, 10 -> ex_mem_alu_result. Code 11 SHALL behave as 00.
REQ-020 Operand A SHALL be forwarded rs1. Operand B SHALL be id_ex_imm when alusrc=1, else forwarded rs2. Forwarding SHALL be applied before the immediate mux.
REQ-021 ALU codes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB. ADD and SUB wrap modulo 2^XLEN. Any unlisted code SHALL yield 0.
REQ-022 zero SHALL be 1 exactly when alu_result==0.
REQ-023 On each rising edge, EX/MEM SHALL capture next_pc_in, zero, alu_result, forwarded rs2 (as store data), id_ex_rd and ctrl_in. Latency is 1 cycle.
REQ-024 When flush=1 at an edge, ex_mem_ctrl and ex_mem_rd SHALL load 0 and data fields SHALL load normally.
REQ-025 Forwarding SHALL use the registered ex_mem_rd and ex_mem_ctrl values, which are the values visible before the edge.

Reset
REQ-026 With reset=1 at a rising edge, every registered output SHALL become 0. Reset SHALL override flush. forward_a/b, alu_result and zero remain combinational.

Configuration
REQ-027 Macro ALU_EXT_OPS_EN: when defined, add 0011 XOR, 0100 SLL, 0101 SRL (shift amount operand B[5:0]) and 0111 SLT (signed, result 1/0). When undefined, these codes SHALL yield 0.

Structure
REQ-028 A shared package SHALL hold the ALU opcode constants, the forwarding-code constants (FWD_NONE/FWD_WB/FWD_MEM) and the ctrl bit-index constants.
REQ-029 The ALU SHALL be one combinational sub-module, ex_alu. Forwarding logic and the EX/MEM register SHALL reside in the top module.

Verification
REQ-030 Scenario: rd1=5, rd2=3, alu_ctrl=0010, no hazards. Required: alu_result=8, zero=0; ex_mem_alu_result=8 after the edge.
REQ-031 Scenario: rd1=7, rd2=7, alu_ctrl=0110. Required: zero=1; ex_mem_zero=1 on the next cycle.
REQ-032 Scenario: prior cycle wrote rd=5 with result 8 and regwrite=1; now rs1=5, stale rd1=1, rd2=2, ADD. Required: forward_a=10, alu_result=10.
REQ-033 Scenario: ex_mem_rd=5 (result 8) and mem_wb_rd=5 (data 99), rs1=5. Required: forward_a=10, operand A=8. With only mem_wb matching, required: forward_a=01, operand A=99.
REQ-034 Scenario: ex_mem_rd=0 with regwrite=1, rs1=0. Required: forward_a=00.
REQ-035 Scenario: reset pulse. Required: all ex_mem_* = 0. Scenario: flush with ctrl_in=5'b11111. Required: ex_mem_ctrl=0, ex_mem_rd=0.
